// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit.
// Opcodes, state encodings, datapath mux codes and the control vector.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH     = 4'd0;
  localparam state_t S_DECODE    = 4'd1;
  localparam state_t S_MEM_ADDR  = 4'd2;
  localparam state_t S_MEM_READ  = 4'd3;
  localparam state_t S_MEM_WB    = 4'd4;
  localparam state_t S_MEM_WRITE = 4'd5;
  localparam state_t S_EXECUTE   = 4'd6;
  localparam state_t S_R_WB      = 4'd7;
  localparam state_t S_BRANCH    = 4'd8;
  localparam state_t S_JUMP      = 4'd9;
  localparam state_t S_ADDI_EX   = 4'd10;
  localparam state_t S_ADDI_WB   = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // True for every opcode the sequencer knows how to run.
  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State to control-vector decoder for the multi-cycle MIPS datapath.
// Purely combinational; only FETCH looks at the memory handshake.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Moore decode, with IR/PC load in FETCH gated by the memory handshake.
  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
      end
      default: ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: state register, sequencing,
// illegal-opcode flag and retired-instruction counter.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             rdy;
  ctrl_t            ctrl;
  ctrl_t            ctrl_g;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (rdy),
    .ctrl_o      (ctrl)
  );

  // Next state; flags instruction retirement and illegal opcodes.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = !op_legal(opcode);
          end
        endcase
      end
      S_MEM_ADDR: begin
        state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        if (rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WRITE: begin
        if (rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_R_WB;
      S_R_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // State, illegal pulse and retirement counter (wraps naturally).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset silences every strobe and select in the same cycle.
  always_comb begin
    ctrl_g = reset ? CTRL_IDLE : ctrl;
  end

  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.iord;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign IRWrite     = ctrl_g.ir_write;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign RegDst      = ctrl_g.reg_dst;
  assign RegWrite    = ctrl_g.reg_write;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign ALUOp       = ctrl_g.alu_op;
  assign PCSource    = ctrl_g.pc_source;
  assign illegal_op  = illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: one default instance and one
// CNT_W=4 / MEM_WAIT=0 instance for counter wrap and handshake bypass.
module tb_mc_control_fsm;

  logic        clock;
  logic        reset, reset2;
  logic [5:0]  opcode, opcode2;
  logic        mem_ready, mem_ready2;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] retired;

  logic        PCWrite2, PCWriteCond2, IorD2, MemRead2, MemWrite2, IRWrite2;
  logic        MemtoReg2, RegDst2, RegWrite2, ALUSrcA2, illegal_op2;
  logic [1:0]  ALUSrcB2, ALUOp2, PCSource2;
  logic [3:0]  retired2;

  int checks;
  int errors;

  mc_control_fsm dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .retired     (retired)
  );

  mc_control_fsm #(.CNT_W(4), .MEM_WAIT(1'b0)) dut2 (
    .clock       (clock),
    .reset       (reset2),
    .opcode      (opcode2),
    .mem_ready   (mem_ready2),
    .PCWrite     (PCWrite2),
    .PCWriteCond (PCWriteCond2),
    .IorD        (IorD2),
    .MemRead     (MemRead2),
    .MemWrite    (MemWrite2),
    .IRWrite     (IRWrite2),
    .MemtoReg    (MemtoReg2),
    .RegDst      (RegDst2),
    .RegWrite    (RegWrite2),
    .ALUSrcA     (ALUSrcA2),
    .ALUSrcB     (ALUSrcB2),
    .ALUOp       (ALUOp2),
    .PCSource    (PCSource2),
    .illegal_op  (illegal_op2),
    .retired     (retired2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step;
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from a settled FETCH back to the next FETCH.
  task automatic measure(input logic [5:0] op, output int cyc,
                         output logic rw, output logic mw,
                         output logic pcwc, output logic jmp);
    logic done;
    opcode    = op;
    mem_ready = 1'b1;
    cyc  = 1;
    rw   = RegWrite;
    mw   = MemWrite;
    pcwc = PCWriteCond;
    jmp  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step;
      #1;
      if (MemRead && !IorD) begin
        done = 1'b1;
      end else begin
        cyc++;
        rw   = rw | RegWrite;
        mw   = mw | MemWrite;
        pcwc = pcwc | PCWriteCond;
        jmp  = jmp | (PCWrite && PCSource == 2'b10);
      end
    end
    if (!done) cyc = -1;
  endtask

  int   cyc;
  logic rw, mw, pcwc, jmp;

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    reset2     = 1'b1;
    opcode     = 6'h00;
    mem_ready  = 1'b1;
    opcode2    = 6'h08;
    mem_ready2 = 1'b0;

    // Held in reset: strobes and selects low, counters clear.
    step; #1;
    chk("rst_memread", MemRead, 1'b0);
    chk("rst_pcwrite", PCWrite, 1'b0);
    chk("rst_irwrite", IRWrite, 1'b0);
    chk("rst_srcb", ALUSrcB, 2'b00);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_retired", retired, 32'd0);

    // lw interrupted by reset in MEM_READ.
    reset  = 1'b0;
    opcode = 6'h23;
    #1;
    chk("f_memread", MemRead, 1'b1);
    chk("f_irwrite", IRWrite, 1'b1);
    chk("f_pcwrite", PCWrite, 1'b1);
    chk("f_srcb", ALUSrcB, 2'b01);
    step; #1;
    chk("dec_srcb", ALUSrcB, 2'b11);
    step; #1;
    chk("maddr_srcb", ALUSrcB, 2'b10);
    chk("maddr_srca", ALUSrcA, 1'b1);
    step;
    mem_ready = 1'b0;
    #1;
    chk("mrd_memread", MemRead, 1'b1);
    chk("mrd_iord", IorD, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_memread", MemRead, 1'b0);
    chk("midrst_iord", IorD, 1'b0);
    chk("midrst_regwrite", RegWrite, 1'b0);
    chk("midrst_memwrite", MemWrite, 1'b0);
    step;
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    #1;
    chk("post_rst_fetch", MemRead && !IorD, 1'b1);
    chk("post_rst_retired", retired, 32'd0);

    // R-type: 4 cycles, write-back in cycle 4 only.
    step; #1;
    chk("r_c2_regwrite", RegWrite, 1'b0);
    step; #1;
    chk("r_c3_aluop", ALUOp, 2'b10);
    chk("r_c3_regwrite", RegWrite, 1'b0);
    step; #1;
    chk("r_c4_regwrite", RegWrite, 1'b1);
    chk("r_c4_regdst", RegDst, 1'b1);
    chk("r_c4_memtoreg", MemtoReg, 1'b0);
    step; #1;
    chk("r_done_fetch", MemRead && !IorD, 1'b1);
    chk("r_retired", retired, 32'd1);

    // lw with two wait cycles in MEM_READ: 7 cycles.
    opcode = 6'h23;
    step; #1;
    step; #1;
    step;
    mem_ready = 1'b0;
    #1;
    chk("lw_mr1_regwrite", RegWrite, 1'b0);
    chk("lw_mr1_memread", MemRead, 1'b1);
    step; #1;
    chk("lw_mr2_iord", IorD, 1'b1);
    step;
    mem_ready = 1'b1;
    #1;
    chk("lw_mr3_regwrite", RegWrite, 1'b0);
    step;
    opcode = 6'h04;
    #1;
    chk("lw_wb_regwrite", RegWrite, 1'b1);
    chk("lw_wb_memtoreg", MemtoReg, 1'b1);
    chk("lw_wb_regdst", RegDst, 1'b0);
    step; #1;
    chk("lw_done_fetch", MemRead && !IorD, 1'b1);
    chk("lw_done_regwrite", RegWrite, 1'b0);
    chk("lw_retired", retired, 32'd2);

    // sw, beq, j back to back.
    measure(6'h2B, cyc, rw, mw, pcwc, jmp);
    chk("sw_cycles", cyc, 32'd4);
    chk("sw_regwrite", rw, 1'b0);
    chk("sw_memwrite", mw, 1'b1);
    measure(6'h04, cyc, rw, mw, pcwc, jmp);
    chk("beq_cycles", cyc, 32'd3);
    chk("beq_regwrite", rw, 1'b0);
    chk("beq_pcwcond", pcwc, 1'b1);
    measure(6'h02, cyc, rw, mw, pcwc, jmp);
    chk("j_cycles", cyc, 32'd3);
    chk("j_regwrite", rw, 1'b0);
    chk("j_jump", jmp, 1'b1);
    chk("sbj_retired", retired, 32'd5);

    // Illegal opcode: FETCH, DECODE, FETCH with a one-cycle flag.
    opcode = 6'h3F;
    #1;
    chk("ill_f_flag", illegal_op, 1'b0);
    step; #1;
    chk("ill_dec_srcb", ALUSrcB, 2'b11);
    chk("ill_dec_flag", illegal_op, 1'b0);
    step;
    mem_ready = 1'b0;
    #1;
    chk("ill_flag", illegal_op, 1'b1);
    chk("ill_fetch", MemRead && !IorD, 1'b1);
    chk("ill_stall_irwrite", IRWrite, 1'b0);
    chk("ill_stall_pcwrite", PCWrite, 1'b0);
    chk("ill_retired", retired, 32'd5);
    step; #1;
    chk("ill_flag_drop", illegal_op, 1'b0);
    chk("stall_hold_fetch", MemRead && !IorD, 1'b1);
    mem_ready = 1'b1;

    // Narrow counter, handshake ignored: 16 addi wrap to zero.
    reset2 = 1'b0;
    #1;
    chk("nw_irwrite", IRWrite2, 1'b1);
    step; #1;
    step; #1;
    step; #1;
    chk("addi_wb_regwrite", RegWrite2, 1'b1);
    chk("addi_wb_regdst", RegDst2, 1'b0);
    step; #1;
    chk("addi1_retired", retired2, 4'd1);
    for (int k = 2; k <= 16; k++) begin
      repeat (4) step;
      #1;
      if (k == 15) chk("addi15_retired", retired2, 4'd15);
      if (k == 16) chk("addi16_wrap", retired2, 4'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
